// File: rtl/uim_fuse_loader_if.sv
// Bit-serial fuse stream with valid/ready handshake between a fuse source and the UIM loader.
interface uim_fuse_loader_if;
    logic fuse_bit;
    logic fuse_valid;
    logic fuse_ready;

    modport master (
        output fuse_bit,
        output fuse_valid,
        input  fuse_ready
    );

    modport slave (
        input  fuse_bit,
        input  fuse_valid,
        output fuse_ready
    );
endinterface

// File: rtl/uim_fuse_loader.sv
// Serial UIM fuse loader: assembles an LSB-first stream in a shadow register, checks an
// even-parity trailer and atomically commits the result to the uim_mux select bus.
module uim_fuse_loader #(
    parameter int unsigned NUM_UIM = 40,
    parameter int unsigned MUX_W   = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    uim_fuse_loader_if.slave           fuse,
    output logic [NUM_UIM*MUX_W-1:0]   uim_mux_bus,
    output logic                       config_valid,
    output logic                       busy,
    output logic                       error
);

    localparam int unsigned N  = NUM_UIM * MUX_W;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PARITY,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    shadow_q, shadow_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            par_q, par_d;
    logic [N-1:0]    bus_q, bus_d;
    logic            cfg_q, cfg_d;
    logic            err_q, err_d;
    logic            loading;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            bus_q    <= '1;
            cfg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            bus_q    <= bus_d;
            cfg_q    <= cfg_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        bus_d    = bus_q;
        cfg_d    = cfg_q;
        err_d    = err_q;

        // start wins over everything, including a bit offered in the same cycle
        if (start) begin
            state_d  = ST_LOAD;
            shadow_d = '0;
            cnt_d    = '0;
            par_d    = 1'b0;
            cfg_d    = 1'b0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (fuse.fuse_valid) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            if (CW'(i) == cnt_q) begin
                                shadow_d[i] = fuse.fuse_bit;
                            end
                        end
                        cnt_d = cnt_q + CW'(1);
                        par_d = par_q ^ fuse.fuse_bit;
                        if (cnt_q == CW'(N - 1)) begin
                            state_d = ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (fuse.fuse_valid) begin
                        if ((par_q ^ fuse.fuse_bit) == 1'b0) begin
                            bus_d   = shadow_q;
                            cfg_d   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_ERROR;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign loading         = (state_q == ST_LOAD) || (state_q == ST_PARITY);
    assign busy            = loading;
    assign fuse.fuse_ready = loading;
    assign uim_mux_bus     = bus_q;
    assign config_valid    = cfg_q;
    assign error           = err_q;

endmodule

// File: tb/tb_uim_fuse_loader.sv
// Randomized scoreboard bench for uim_fuse_loader (NUM_UIM=2, MUX_W=5).
module tb_uim_fuse_loader;

    localparam int unsigned NUM_UIM = 2;
    localparam int unsigned MUX_W   = 5;
    localparam int          N       = NUM_UIM * MUX_W;

    typedef struct {
        logic [N-1:0] bus;
        logic         cfg;
        logic         err;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] uim_mux_bus;
    logic         config_valid;
    logic         busy;
    logic         error;

    uim_fuse_loader_if fif ();

    uim_fuse_loader #(.NUM_UIM(NUM_UIM), .MUX_W(MUX_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .fuse         (fif.slave),
        .uim_mux_bus  (uim_mux_bus),
        .config_valid (config_valid),
        .busy         (busy),
        .error        (error)
    );

    int           tests = 0;
    int           fails = 0;
    int           cyc   = 0;
    exp_t         q[$];
    logic [N-1:0] committed;
    logic [N-1:0] model_bus;
    bit           mon_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_toggle(input int cycles, input logic exp_cfg, input logic exp_err);
        for (int i = 0; i < cycles; i++) begin
            fif.fuse_valid = 1'($urandom);
            fif.fuse_bit   = 1'($urandom);
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_ready", fif.fuse_ready, 0);
            check("idle_cfg", config_valid, exp_cfg);
            check("idle_err", error, exp_err);
        end
        fif.fuse_valid = 1'b0;
    endtask

    // mode 0: no stalls, 1: stall before every bit but the first, 2: random stalls
    task automatic run_load(input logic [N-1:0] bits, input logic trailer, input int mode, input bit do_start);
        exp_t e;
        int   stalls;
        int   cyc_start;
        logic good;
        if (do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        cyc_start = cyc;
        check("busy_after_start", busy, 1);
        check("ready_after_start", fif.fuse_ready, 1);
        check("cfg_cleared", config_valid, 0);
        check("err_cleared", error, 0);
        stalls = 0;
        good   = ((^bits) ^ trailer) == 1'b0;
        e.bus  = good ? bits : committed;
        e.cfg  = good;
        e.err  = !good;
        e.cyc  = 0;
        for (int k = 0; k <= N; k++) begin
            if ((mode == 1 && k > 0) || (mode == 2 && $urandom_range(3) == 0)) begin
                fif.fuse_valid = 1'b0;
                fif.fuse_bit   = 1'($urandom);
                stalls++;
                @(negedge clk);
            end
            if (k == N) begin
                e.cyc = cyc_start + N + 1 + stalls;
                q.push_back(e);
            end
            fif.fuse_valid = 1'b1;
            fif.fuse_bit   = (k < N) ? bits[k] : trailer;
            @(negedge clk);
        end
        fif.fuse_valid = 1'b0;
        committed = e.bus;
        check("load_busy_end", busy, 0);
        check("load_cfg", config_valid, e.cfg);
        check("load_err", error, e.err);
        idle_toggle(3, e.cfg, e.err);
    endtask

    // monitor: every fall of busy must match the oldest expected outcome
    initial begin
        exp_t e;
        logic prev_busy;
        prev_busy = 1'b0;
        wait (mon_en);
        forever begin
            @(posedge clk);
            #1;
            if (prev_busy && !busy) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_end: busy fell with no expected outcome (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    check("sb_bus", uim_mux_bus, e.bus);
                    check("sb_cfg", config_valid, e.cfg);
                    check("sb_err", error, e.err);
                    if (e.cyc >= 0) check("sb_latency", cyc, e.cyc);
                    model_bus = e.bus;
                end
            end else begin
                check("bus_hold", uim_mux_bus, model_bus);
            end
            prev_busy = busy;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t         e;
        logic [N-1:0] bits;
        logic         tr;
        int           mode;

        reset          = 1'b1;
        start          = 1'b0;
        fif.fuse_valid = 1'b0;
        fif.fuse_bit   = 1'b0;
        committed      = '1;
        model_bus      = '1;
        repeat (3) @(negedge clk);
        check("rst_bus", uim_mux_bus, 10'h3FF);
        check("rst_cfg", config_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", error, 0);
        check("rst_ready", fif.fuse_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_bus", uim_mux_bus, 10'h3FF);
        mon_en = 1;
        idle_toggle(4, 1'b0, 1'b0);

        // parity error from reset, then good, then alternate-cycle backpressure
        run_load(10'h1FE, 1'b1, 0, 1);
        run_load(10'h1FE, 1'b0, 0, 1);
        run_load(10'h1FE, 1'b0, 1, 1);

        // restart mid-load; the bit offered with the second start must be dropped
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fif.fuse_valid = 1'b1;
            fif.fuse_bit   = 1'($urandom);
            @(negedge clk);
        end
        start          = 1'b1;
        fif.fuse_valid = 1'b1;
        fif.fuse_bit   = 1'b0;
        @(negedge clk);
        start          = 1'b0;
        fif.fuse_valid = 1'b0;
        run_load(10'h3DF, 1'b1, 0, 0);
        check("restart_bus", uim_mux_bus, 10'h3DF);

        // reset mid-load aborts and restores all ones
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fif.fuse_valid = 1'b1;
            fif.fuse_bit   = 1'($urandom);
            @(negedge clk);
        end
        fif.fuse_valid = 1'b0;
        e.bus = '1;
        e.cfg = 1'b0;
        e.err = 1'b0;
        e.cyc = -1;
        q.push_back(e);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        committed = '1;
        check("midrst_bus", uim_mux_bus, 10'h3FF);
        idle_toggle(4, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            bits = N'($urandom);
            tr   = ($urandom_range(3) == 0) ? ~(^bits) : (^bits);
            mode = $urandom_range(2);
            run_load(bits, tr, mode, 1);
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expected outcomes never observed", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
